// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: binary result register value to packed BCD digits.
// Optional signed-input mode is enabled by defining BCD_SIGNED_INPUT_EN.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_neg
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned MaxBin = (64'd1 << WIDTH) - 64'd1;

  if (!(pow10(DIGITS) > MaxBin)) begin : g_bad_params
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [SrW-1:0]    r_sr, w_sr_next, w_sr_adj, w_sr_shifted, w_sr_load;
  logic [CntW-1:0]   r_cnt, w_cnt_next;
  logic              r_sign, w_sign_next;
  logic [BcdW-1:0]   r_bcd, w_bcd_next;
  logic              r_neg, w_neg_next;
  logic [WIDTH:0]    w_mag;
  logic              w_sign_in;
  logic              w_last_shift;

`ifdef BCD_SIGNED_INPUT_EN
  logic [WIDTH:0] w_bin_ext;
  assign w_bin_ext = {i_bin[WIDTH-1], i_bin};
  // Negate in WIDTH+1 bits so the most-negative input yields its true magnitude.
  assign w_mag     = i_bin[WIDTH-1] ? ({(WIDTH+1){1'b0}} - w_bin_ext) : w_bin_ext;
  assign w_sign_in = i_bin[WIDTH-1];
`else
  assign w_mag     = {1'b0, i_bin};
  assign w_sign_in = 1'b0;
`endif

  assign w_sr_load    = SrW'(w_mag);
  assign w_last_shift = (r_cnt == CntW'(WIDTH - 1));

  // Add 3 to every BCD nibble that is 5 or more, then shift.
  always_comb begin
    w_sr_adj = r_sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_sr[WIDTH + 4*d +: 4] >= 4'd5) begin
        w_sr_adj[WIDTH + 4*d +: 4] = r_sr[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_sr_shifted = {w_sr_adj[SrW-2:0], 1'b0};

  // State register and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_sign  <= w_sign_next;
      r_bcd   <= w_bcd_next;
      r_neg   <= w_neg_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StShift;
      StShift: if (w_last_shift) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath next values; result registers only move on the final shift.
  always_comb begin
    w_sr_next   = r_sr;
    w_cnt_next  = r_cnt;
    w_sign_next = r_sign;
    w_bcd_next  = r_bcd;
    w_neg_next  = r_neg;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_sr_next   = w_sr_load;
          w_cnt_next  = '0;
          w_sign_next = w_sign_in;
        end
      end
      StShift: begin
        w_sr_next  = w_sr_shifted;
        w_cnt_next = r_cnt + CntW'(1);
        if (w_last_shift) begin
          w_bcd_next = w_sr_shifted[SrW-1 -: BcdW];
          w_neg_next = r_sign;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    o_busy = (r_state != StIdle);
    o_done = (r_state == StDone);
    o_bcd  = r_bcd;
    o_neg  = r_neg;
  end

endmodule
